// File: rtl/touch_pkg.sv
// Shared definitions for the touch pad reader: event codes, FSM states and
// the counter width helper.
package touch_pkg;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } state_t;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/touch_evt_buf.sv
// One-entry valid/ready event buffer; a raise that finds the slot occupied
// and not being drained is dropped and latches a sticky overrun flag.
module touch_evt_buf
    import touch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raise,
    input  logic [1:0] code_in,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] code,
    output logic       overrun
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            code    <= EVT_NONE;
            overrun <= 1'b0;
        end else if (raise) begin
            if (!valid || ready) begin
                valid <= 1'b1;
                code  <= code_in;
            end else begin
                overrun <= 1'b1;
            end
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/touch_pad_reader.sv
// Fomu touch pad / button reader: 2-flop sync, debounce FSM, press/release/long
// events over valid/ready. Define TOUCH_REPEAT_EN for periodic LONG auto-repeat.
module touch_pad_reader
    import touch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 480000,
    parameter int LONG_PRESS_CYCLES = 48000000,
    parameter int ACTIVE_LOW        = 1
`ifdef TOUCH_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES     = 12000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_in,
    output logic       pressed,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overrun,
    output logic [7:0] press_count
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int LW = cnt_w(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_PRE  = LW'(LONG_PRESS_CYCLES - 2);
    localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0);

    logic [1:0]    sync;
    logic          act;
    state_t        state;
    logic [DW-1:0] db_cnt;
    logic [LW-1:0] hold_cnt;
    logic          long_done;
    logic          press_fire, rel_fire, long_fire, rep_fire;
    logic          raise;
    logic [1:0]    raise_code;

    always_ff @(posedge clk) begin
        if (!rst_n) sync <= {2{IDLE_LVL}};
        else        sync <= {sync[0], pad_in};
    end

    assign act = sync[1] ^ IDLE_LVL;

`ifdef TOUCH_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
    assign rep_fire = (state == ST_HELD) && act && long_done && (rep_cnt == REP_LAST);
`else
    assign rep_fire = 1'b0;
`endif

    // LONG fires on the edge where hold_cnt steps onto LONG_PRESS_CYCLES-1.
    assign press_fire = (state == ST_PRESS_WAIT)   &&  act && (db_cnt == DB_LAST);
    assign rel_fire   = (state == ST_RELEASE_WAIT) && !act && (db_cnt == DB_LAST);
    assign long_fire  = (state == ST_HELD) && act && !long_done && (hold_cnt >= HOLD_PRE);

    always_comb begin
        raise      = press_fire | rel_fire | long_fire | rep_fire;
        raise_code = EVT_NONE;
        if (press_fire)                  raise_code = EVT_PRESS;
        else if (rel_fire)               raise_code = EVT_RELEASE;
        else if (long_fire || rep_fire)  raise_code = EVT_LONG;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            pressed     <= 1'b0;
            press_count <= 8'd0;
`ifdef TOUCH_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (act) begin
                        state  <= ST_PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!act) begin
                        state <= ST_IDLE;
                    end else if (press_fire) begin
                        state       <= ST_HELD;
                        pressed     <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
`ifdef TOUCH_REPEAT_EN
                        rep_cnt     <= '0;
`endif
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                ST_HELD: begin
                    if (!act) begin
                        state  <= ST_RELEASE_WAIT;
                        db_cnt <= '0;
                    end else begin
                        if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + LW'(1);
                        if (long_fire) long_done <= 1'b1;
`ifdef TOUCH_REPEAT_EN
                        if (long_done) rep_cnt <= rep_fire ? '0 : rep_cnt + RW'(1);
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A bounce back to touched resumes the same press.
                    if (act) begin
                        state <= ST_HELD;
                    end else if (rel_fire) begin
                        state   <= ST_IDLE;
                        pressed <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    touch_evt_buf u_evt_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raise   (raise),
        .code_in (raise_code),
        .ready   (evt_ready),
        .valid   (evt_valid),
        .code    (evt_code),
        .overrun (evt_overrun)
    );

endmodule

// File: tb/tb_touch_pad_reader.sv
// Scoreboard bench for touch_pad_reader (DEBOUNCE=4, LONG=20, active-low pad).
module tb_touch_pad_reader;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pad_in;
    logic       pressed;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       evt_overrun;
    logic [7:0] press_count;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    touch_pad_reader #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .ACTIVE_LOW        (1)
`ifdef TOUCH_REPEAT_EN
        ,
        .REPEAT_CYCLES     (R)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pad_in      (pad_in),
        .pressed     (pressed),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_overrun (evt_overrun),
        .press_count (press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every handshake must match the head of the scoreboard in code and cycle.
    always @(negedge clk) begin
        #2;
        if (rst_n && evt_valid && evt_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_evt: got code %0d at cycle %0d, want no event", evt_code, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (evt_code !== mon_e.code || cyc != mon_e.cyc) begin
                    n_miss++;
                    $display("FAIL evt: got code %0d at cycle %0d, want code %0d at cycle %0d",
                             evt_code, cyc, mon_e.code, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Touch for n cycles then release; events land 7 edges after each pad change.
    task automatic press_rel(input int n, input int gap);
        int t0;
        t0 = cyc;
        pad_in = 1'b0;
        push(2'b01, t0 + 7);
        if (t0 + 7 + (L - 1) <= t0 + n + 2) begin
            push(2'b11, t0 + 7 + (L - 1));
`ifdef TOUCH_REPEAT_EN
            for (int t = t0 + 7 + (L - 1) + R; t <= t0 + n + 2; t += R) push(2'b11, t);
`endif
        end
        wait_cyc(n);
        pad_in = 1'b1;
        push(2'b10, t0 + n + 7);
        wait_cyc(gap);
    endtask

    initial begin
        int t0;
        logic seen;

        rst_n = 1'b0;
        pad_in = 1'b1;
        evt_ready = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        chk("rst_pressed", pressed, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_overrun", evt_overrun, 0);
        chk("rst_count", press_count, 0);

        wait_cyc(50);
        chk("idle_pressed", pressed, 0);
        chk("idle_count", press_count, 0);

        // Short clean press: pressed rises exactly 7 edges after the pad drive.
        t0 = cyc;
        pad_in = 1'b0;
        push(2'b01, t0 + 7);
        wait_cyc(6);
        chk("lat_pressed_early", pressed, 0);
        wait_cyc(1);
        chk("lat_pressed", pressed, 1);
        wait_cyc(3);
        pad_in = 1'b1;
        push(2'b10, t0 + 17);
        wait_cyc(12);
        chk("short_released", pressed, 0);
        chk("short_count", press_count, 1);

        // Glitches of 1..3 cycles never get through the debounce.
        seen = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            pad_in = 1'b0;
            for (int i = 0; i < w; i++) begin wait_cyc(1); seen |= pressed; end
            pad_in = 1'b1;
            for (int i = 0; i < 5; i++) begin wait_cyc(1); seen |= pressed; end
        end
        for (int i = 0; i < 10; i++) begin wait_cyc(1); seen |= pressed; end
        chk("glitch_pressed", seen, 0);
        chk("glitch_count", press_count, 1);

        press_rel(40, 15);
        chk("long_released", pressed, 0);
        chk("long_count", press_count, 2);

        // Consumer stalled: PRESS held, RELEASE dropped, overrun sticks.
        evt_ready = 1'b0;
        t0 = cyc;
        pad_in = 1'b0;
        wait_cyc(10);
        pad_in = 1'b1;
        push(2'b01, t0 + 30);
        wait_cyc(10);
        chk("ovr_valid", evt_valid, 1);
        chk("ovr_code_held", evt_code, 1);
        chk("ovr_flag", evt_overrun, 1);
        wait_cyc(10);
        chk("ovr_code_stable", evt_code, 1);
        evt_ready = 1'b1;
        wait_cyc(1);
        chk("ovr_drained", evt_valid, 0);
        chk("ovr_sticky", evt_overrun, 1);
        chk("ovr_count", press_count, 3);
        wait_cyc(5);

        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        chk("rst2_overrun", evt_overrun, 0);
        chk("rst2_count", press_count, 0);

        for (int i = 0; i < 255; i++) press_rel(6, 8);
        chk("count_255", press_count, 255);
        press_rel(6, 8);
        chk("count_wrap", press_count, 0);

        // Reset while held: outputs clear on the next edge and no RELEASE appears.
        t0 = cyc;
        pad_in = 1'b0;
        push(2'b01, t0 + 7);
        wait_cyc(12);
        chk("mid_pressed", pressed, 1);
        rst_n = 1'b0;
        pad_in = 1'b1;
        wait_cyc(1);
        chk("mid_rst_pressed", pressed, 0);
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_count", press_count, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        chk("mid_after_pressed", pressed, 0);
        chk("mid_after_code", evt_code, 0);

        chk("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
